// File: rtl/reg_file_pkg.sv
// Shared definitions for the 2-read/1-write register file: clear-FSM state
// encoding and the byte-lane merge helper used by the write path and the
// read-port bypass.
package reg_file_pkg;

    // Clear sequencer states; CLEAR is also the state forced by reset.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Select one byte lane: the new byte when its enable is set, else the old one.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be_bit
    );
        logic [7:0] result;
        if (be_bit) begin
            result = new_byte;
        end else begin
            result = old_byte;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port. Produces the stored word, the write-first merge
// when the same-edge write hits this address, or zero for an out-of-range
// address, and registers it together with its valid flag.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rd_en,     // already qualified with not-busy
    input  logic               i_addr_ok,   // read address is below DEPTH
    input  logic               i_wr_hit,    // a committed write targets this address
    input  logic [WIDTH-1:0]   i_mem_word,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic [WIDTH/8-1:0] i_wr_be,
    output logic [WIDTH-1:0]   o_rd_data,
    output logic               o_rd_valid
);

    localparam int BW = WIDTH / 8;

    logic [WIDTH-1:0] w_bypass_word;
    logic [WIDTH-1:0] w_next_data;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    // Pick the word to capture: zero out of range, write-first merge on a hit, else storage.
    always_comb begin
        w_bypass_word = i_mem_word;
        for (int i = 0; i < BW; i++) begin
            w_bypass_word[8*i +: 8] = merge_byte(i_mem_word[8*i +: 8],
                                                 i_wr_data[8*i +: 8],
                                                 i_wr_be[i]);
        end
        if (!i_addr_ok) begin
            w_next_data = {WIDTH{1'b0}};
        end else if (i_wr_hit) begin
            w_next_data = w_bypass_word;
        end else begin
            w_next_data = i_mem_word;
        end
    end

    // Read data/valid registers; data holds its last value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= {WIDTH{1'b0}};
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_next_data;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one byte-enabled write port and two independent
// registered read ports. A clear sequencer writes INIT_VAL into every entry,
// one per cycle; it runs after reset and on request, and blocks all accesses
// while it is active. The storage array itself is never reset.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}},
    localparam int              AW       = $clog2(DEPTH),
    localparam int              BW       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [BW-1:0]    wr_be,
    input  logic             rd_en_a,
    input  logic             rd_en_b,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid_a,
    output logic             rd_valid_b,
    output logic             busy,
    output logic             clr_done
);

    // One extra bit so DEPTH itself is representable for range compares.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];

    clr_state_t       r_state;
    clr_state_t       w_state_nxt;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_nxt;
    logic             r_clr_done;
    logic             w_clr_done_nxt;

    logic             w_busy;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_wr_word;

    logic             w_rd_ok_a;
    logic             w_rd_ok_b;
    logic             w_rd_en_a;
    logic             w_rd_en_b;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [WIDTH-1:0] w_word_a;
    logic [WIDTH-1:0] w_word_b;

    assign w_busy    = (r_state == ST_CLEAR);
    assign w_wr_ok   = wr_en & ~w_busy & ({1'b0, wr_addr} < DEPTH_W);
    assign w_rd_ok_a = ({1'b0, rd_addr_a} < DEPTH_W);
    assign w_rd_ok_b = ({1'b0, rd_addr_b} < DEPTH_W);
    assign w_rd_en_a = rd_en_a & ~w_busy;
    assign w_rd_en_b = rd_en_b & ~w_busy;
    assign w_hit_a   = w_wr_ok & (wr_addr == rd_addr_a);
    assign w_hit_b   = w_wr_ok & (wr_addr == rd_addr_b);

    // Fetch the stored words addressed by the write and both read ports.
    always_comb begin
        w_wr_old = {WIDTH{1'b0}};
        w_word_a = {WIDTH{1'b0}};
        w_word_b = {WIDTH{1'b0}};
        if (w_wr_ok) begin
            w_wr_old = r_mem[wr_addr];
        end else begin
            w_wr_old = {WIDTH{1'b0}};
        end
        if (w_rd_ok_a) begin
            w_word_a = r_mem[rd_addr_a];
        end else begin
            w_word_a = {WIDTH{1'b0}};
        end
        if (w_rd_ok_b) begin
            w_word_b = r_mem[rd_addr_b];
        end else begin
            w_word_b = {WIDTH{1'b0}};
        end
    end

    // Byte-enable merge of incoming write data into the addressed entry.
    always_comb begin
        w_wr_word = w_wr_old;
        for (int i = 0; i < BW; i++) begin
            w_wr_word[8*i +: 8] = merge_byte(w_wr_old[8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
        end
    end

    // Storage update: the clear sequencer owns the array while busy, else the write port.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_idx] <= INIT_VAL;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= w_wr_word;
        end
    end

    // Clear sequencer next state: start on clr in IDLE, step one entry per cycle in CLEAR.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_clr_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = {AW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt    = ST_IDLE;
                    w_idx_nxt      = {AW{1'b0}};
                    w_clr_done_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = {AW{1'b0}};
            end
        endcase
    end

    // Clear sequencer registers; reset forces a fresh clear from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_idx      <= {AW{1'b0}};
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    reg_file_rd_port #(.WIDTH(WIDTH)) u_rd_port_a (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (w_rd_en_a),
        .i_addr_ok  (w_rd_ok_a),
        .i_wr_hit   (w_hit_a),
        .i_mem_word (w_word_a),
        .i_wr_data  (wr_data),
        .i_wr_be    (wr_be),
        .o_rd_data  (rd_data_a),
        .o_rd_valid (rd_valid_a)
    );

    reg_file_rd_port #(.WIDTH(WIDTH)) u_rd_port_b (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (w_rd_en_b),
        .i_addr_ok  (w_rd_ok_b),
        .i_wr_hit   (w_hit_b),
        .i_mem_word (w_word_b),
        .i_wr_data  (wr_data),
        .i_wr_be    (wr_be),
        .o_rd_data  (rd_data_b),
        .o_rd_valid (rd_valid_b)
    );

    assign busy     = w_busy;
    assign clr_done = r_clr_done;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w (WIDTH=16, DEPTH=6, INIT_VAL=A5A5): directed
// scenarios followed by random traffic, all checked against a behavioural
// model of the register file kept here.
module tb_reg_file_2r1w;

    localparam int          DEPTH = 6;
    localparam logic [15:0] INIT  = 16'hA5A5;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en_a;
    logic        rd_en_b;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_valid_a;
    logic        rd_valid_b;
    logic        busy;
    logic        clr_done;

    reg_file_2r1w #(.WIDTH(16), .DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .rd_en_a    (rd_en_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .rd_valid_a (rd_valid_a),
        .rd_valid_b (rd_valid_b),
        .busy       (busy),
        .clr_done   (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents, remaining clear cycles, expected outputs.
    logic [15:0] m_mem [DEPTH];
    int          m_clr_left;
    logic        m_done;
    logic        m_va, m_vb;
    logic [15:0] m_da, m_db;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // The clear is only observable as a whole, so the model fills every entry at once.
    task automatic model_reset();
        m_clr_left = DEPTH;
        m_done = 1'b0;
        m_va = 1'b0; m_vb = 1'b0;
        m_da = 16'h0000; m_db = 16'h0000;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [15:0] v;
        if (a >= 3'd6) return 16'h0000;
        v = m_mem[a];
        if (wr_en && wr_addr == a) begin
            for (int i = 0; i < 2; i++) if (wr_be[i]) v[8*i +: 8] = wr_data[8*i +: 8];
        end
        return v;
    endfunction

    task automatic model_edge();
        logic [15:0] v;
        if (m_clr_left > 0) begin
            m_va = 1'b0;
            m_vb = 1'b0;
            m_clr_left--;
            m_done = (m_clr_left == 0);
        end else begin
            m_done = 1'b0;
            m_va = rd_en_a;
            m_vb = rd_en_b;
            if (rd_en_a) m_da = model_read(rd_addr_a);
            if (rd_en_b) m_db = model_read(rd_addr_b);
            if (wr_en && wr_addr < 3'd6) begin
                v = m_mem[wr_addr];
                for (int i = 0; i < 2; i++) if (wr_be[i]) v[8*i +: 8] = wr_data[8*i +: 8];
                m_mem[wr_addr] = v;
            end
            if (clr) begin
                m_clr_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".busy"},  16'(busy),       16'(m_clr_left > 0));
        check_eq({tag, ".done"},  16'(clr_done),   16'(m_done));
        check_eq({tag, ".va"},    16'(rd_valid_a), 16'(m_va));
        check_eq({tag, ".vb"},    16'(rd_valid_b), 16'(m_vb));
        check_eq({tag, ".da"},    rd_data_a,       m_da);
        check_eq({tag, ".db"},    rd_data_b,       m_db);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; wr_be = 2'b00;
        rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all("reset");

        // Power-up clear: DEPTH busy cycles then a single done pulse.
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick("pwr_clear");
        check_eq("pwr_done_pulse", 16'(clr_done), 16'h0001);
        tick("post_done");

        // Every entry reads INIT on both ports.
        for (int a = 0; a < DEPTH; a++) begin
            rd_en_a = 1'b1; rd_addr_a = a[2:0];
            rd_en_b = 1'b1; rd_addr_b = 3'(DEPTH - 1 - a);
            tick("init_rd");
            check_eq("init_a", rd_data_a, INIT);
        end
        idle_inputs();

        // Full write then low-byte-only overwrite.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; wr_be = 2'b11;
        tick("wr3_full");
        wr_data = 16'hFFFF; wr_be = 2'b01;
        tick("wr3_lo");
        idle_inputs();
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        tick("rd3");
        check_eq("bytemerge_12FF", rd_data_a, 16'h12FF);

        // Same-edge write and read: write-first with byte enables.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF; wr_be = 2'b10;
        rd_en_a = 1'b1; rd_addr_a = 3'd2;
        tick("bypass");
        check_eq("bypass_BEA5", rd_data_a, 16'hBEA5);
        check_eq("bypass_valid", 16'(rd_valid_a), 16'h0001);

        // Out-of-range write ignored; out-of-range read returns zero but valid.
        idle_inputs();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h5555; wr_be = 2'b11;
        rd_en_b = 1'b1; rd_addr_b = 3'd7;
        tick("oor");
        check_eq("oor_zero", rd_data_b, 16'h0000);
        check_eq("oor_valid", 16'(rd_valid_b), 16'h0001);
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            rd_en_b = 1'b1; rd_addr_b = a[2:0];
            tick("oor_scan");
        end
        idle_inputs();

        // Clear request; accesses and a second clr during busy are ignored.
        clr = 1'b1;
        tick("clr_start");
        clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 3'd1;
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0000; wr_be = 2'b11;
            clr = (i == 2);
            tick("clr_busy");
            check_eq("busy_no_valid", 16'(rd_valid_a), 16'h0000);
        end
        idle_inputs();
        check_eq("clr_done_pulse", 16'(clr_done), 16'h0001);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en_a = 1'b1; rd_addr_a = a[2:0];
            tick("after_clr");
            check_eq("after_clr_a", rd_data_a, INIT);
        end
        idle_inputs();

        // Reset in the middle of a clear restarts it from entry 0.
        clr = 1'b1;
        tick("clr2_start");
        clr = 1'b0;
        for (int i = 0; i < 3; i++) tick("clr2_partial");
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick("restart");
            check_eq("restart_busy", 16'(busy), 16'h0001);
        end
        tick("restart_last");
        check_eq("restart_done", 16'(clr_done), 16'h0001);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            clr       = ($urandom_range(0, 39) == 0);
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            wr_be     = 2'($urandom_range(0, 3));
            rd_en_a   = ($urandom_range(0, 2) != 0);
            rd_en_b   = ($urandom_range(0, 2) != 0);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            tick("rand");
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of entries; any value >= 2, power of two not required.
REQ-003 Parameter INIT_VAL, default 0: value written to every entry by the clear sequence.
REQ-004 Derived constants: AW = $clog2(DEPTH); BW = WIDTH/8.
REQ-005 Port list, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- clr  in  1  single-cycle request to start a clear sequence.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- wr_be  in  BW  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en_a / rd_en_b  in  1  read strobes, ports A and B.
- rd_addr_a / rd_addr_b  in  AW  read addresses.
- rd_data_a / rd_data_b  out  WIDTH  registered read data.
- rd_valid_a / rd_valid_b  out  1  rd_data_x valid this cycle.
- busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when a clear sequence completes.

Function
REQ-006 A write SHALL occur on the clk edge where wr_en=1 and busy=0; only bytes with wr_be[i]=1 are updated.
REQ-007 A write with wr_addr >= DEPTH SHALL be ignored.
REQ-008 Reads SHALL have latency 1: rd_en_x=1 with busy=0 at edge N gives rd_valid_x=1 and rd_data_x during cycle N+1.
REQ-009 rd_valid_x SHALL be 0 in any cycle not produced by REQ-008; rd_data_x SHALL hold its last value when rd_valid_x=0.
REQ-010 Read with rd_addr_x >= DEPTH SHALL return all zeros with rd_valid_x=1.
REQ-011 Same-edge read and write to the same address SHALL be write-first: enabled bytes come from wr_data, the other bytes come from the stored entry.
REQ-012 Ports A and B SHALL be fully independent and may read the same address in the same cycle.
REQ-013 Clear FSM states: IDLE, CLEAR.
- IDLE -> CLEAR when clr=1 (index := 0).
- CLEAR writes INIT_VAL to entry index, one entry per cycle, index++.
- CLEAR -> IDLE after the edge that writes entry DEPTH-1; clr_done=1 for exactly the following cycle.
REQ-014 busy SHALL be 1 exactly while the state is CLEAR; a clear takes DEPTH cycles.
REQ-015 While busy=1, wr_en, rd_en_a/b and clr SHALL be ignored; a clr in CLEAR does not restart the sequence.
REQ-016 A clr on the same edge as a wr_en/rd_en in IDLE SHALL start the clear; that write and read are still performed.

Reset
REQ-017 When rst is asserted the block SHALL asynchronously set: state = CLEAR, index = 0, busy = 1, rd_valid_a/b = 0, rd_data_a/b = 0, clr_done = 0.
REQ-018 After rst deasserts, the block SHALL complete a full DEPTH-cycle clear before accepting any access; reset mid-clear restarts at index 0.
REQ-019 Storage array SHALL NOT be reset directly; only the clear sequence initialises it.

Structure
REQ-020 Shared package reg_file_pkg SHALL hold the FSM state encoding (IDLE, CLEAR) and the byte-merge helper function.
REQ-021 One sub-module, reg_file_rd_port, SHALL implement the registered read, bypass merge and valid logic; it is instantiated twice (A, B).
REQ-022 Target size: 120-400 lines of RTL total.

Verification (WIDTH=16, DEPTH=6, INIT_VAL=16'hA5A5)
REQ-023 Release rst -> busy=1 for 6 cycles, then clr_done pulses once; reads of addresses 0-5 return A5A5.
REQ-024 Write addr 3 with 16'h1234, wr_be=2'b11; next cycle write addr 3 with 16'hFFFF, wr_be=2'b01 -> read of addr 3 returns 12FF.
REQ-025 Same edge: write addr 2 with 16'hBEEF, wr_be=2'b10, and port A reads addr 2 (holding A5A5) -> rd_data_a=BEA5 with rd_valid_a=1 next cycle.
REQ-026 Write addr 7 -> no entry changes; port B read of addr 7 -> rd_data_b=0000, rd_valid_b=1.
REQ-027 Pulse clr, then assert rd_en_a and wr_en during busy -> rd_valid_a stays 0 and the write is dropped; after clr_done all entries read A5A5.
REQ-028 Assert rst at clear index 3 -> busy stays 1 and the clear restarts at 0; clr_done occurs 6 cycles after rst deasserts.
